// File: rtl/rr_grant_arbiter8.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter8 : 8-way round-robin arbiter with ownership hold and timeout
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_grant_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [2:0] winner;
  logic [2:0] idx;
  logic       any_req;
  logic       owner_active;
  logic       hold_expired;
  logic       release_grant;

  // Scan from the highest offset down so the lowest offset past ptr wins last.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i) + 3'd1;
      if (req[idx]) winner = idx;
    end
  end

  assign any_req       = |req;
  assign owner_active  = req[gnt_id_q];
  assign hold_expired  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign release_grant = done || !owner_active || hold_expired;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_d       = 8'(1) << winner;
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
          ptr_d       = winner;
          hold_cnt_d  = '0;
        end else begin
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        hold_cnt_d = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
        if (release_grant) begin
          // Only a pure timeout is reported; done or withdrawal wins the tie.
          timeout_d = hold_expired && !done && owner_active;
          if (any_req) begin
            gnt_d       = 8'(1) << winner;
            gnt_id_d    = winner;
            gnt_valid_d = 1'b1;
            ptr_d       = winner;
            hold_cnt_d  = '0;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd7;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_arbiter8.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_arbiter8 : directed and constrained-random checks for the arbiter
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rr_grant_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_total;
  int n_pass;

  rr_grant_arbiter8 #(
    .MAX_HOLD(16),
    .CNT_W   (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] id);
    check({tag, "_id"},    32'(gnt_id),    32'(id));
    check({tag, "_gnt"},   32'(gnt),       32'(8'(1) << id));
    check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
  endtask

  int         wait_cnt [8];
  logic [7:0] app_req;
  logic       prev_valid;
  logic [2:0] prev_id;
  logic       new_grant;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    req     = '0;
    done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",     32'(gnt),       32'd0);
    check("rst_id",      32'(gnt_id),    32'd0);
    check("rst_valid",   32'(gnt_valid), 32'd0);
    check("rst_timeout", 32'(timeout),   32'd0);
    rst_n = 1'b1;

    // First grant after reset: requester 0 is highest priority, 1 is first set
    req = 8'b1000_1010;
    tick();
    check_grant("first", 3'd1);

    // Rotation on done, no idle bubbles
    done = 1'b1;
    tick();
    check_grant("rot3", 3'd3);
    tick();
    check_grant("rot7", 3'd7);
    tick();
    check_grant("wrap1", 3'd1);
    done = 1'b0;

    // Owner 1 withdraws, sole requester 2 then runs into the hold limit
    req = 8'b0000_0100;
    tick();
    check_grant("own2", 3'd2);
    check("own2_to", 32'(timeout), 32'd0);
    repeat (15) tick();
    check_grant("hold2", 3'd2);
    check("hold2_to", 32'(timeout), 32'd0);
    tick();
    check("to_pulse", 32'(timeout), 32'd1);
    check_grant("regrant2", 3'd2);
    tick();
    check("to_clear", 32'(timeout), 32'd0);
    check_grant("still2", 3'd2);

    // Withdrawal handoff and return to idle
    req = 8'b0010_0000;
    tick();
    check_grant("own5", 3'd5);
    req = 8'b0000_0001;
    tick();
    check_grant("wd_to0", 3'd0);
    check("wd_no_to", 32'(timeout), 32'd0);
    req  = 8'b0000_0000;
    done = 1'b1;
    tick();
    check("idle_gnt",   32'(gnt),       32'd0);
    check("idle_valid", 32'(gnt_valid), 32'd0);
    done = 1'b0;
    tick();
    check("idle_stay", 32'(gnt_valid), 32'd0);

    // Asynchronous reset mid-grant
    req = 8'b0100_0000;
    tick();
    check_grant("own6", 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt",   32'(gnt),       32'd0);
    check("arst_valid", 32'(gnt_valid), 32'd0);
    check("arst_id",    32'(gnt_id),    32'd0);
    req = 8'b0100_0001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_grant("post_rst", 3'd0);

    // Random traffic: non-owners keep requesting until served
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    prev_valid = gnt_valid;
    prev_id    = gnt_id;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      app_req = req;
      tick();
      check("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      if (gnt_valid) check("inv_idmatch", 32'(gnt), 32'(8'(1) << gnt_id));
      else           check("inv_idle",    32'(gnt), 32'd0);
      new_grant = gnt_valid && (!prev_valid || gnt_id != prev_id);
      if (new_grant) begin
        for (int i = 0; i < 8; i++) begin
          if (i == int'(gnt_id)) wait_cnt[i] = 0;
          else if (app_req[i]) begin
            wait_cnt[i]++;
            check("fair_wait", 32'(wait_cnt[i] <= 7), 32'd1);
          end else wait_cnt[i] = 0;
        end
      end
      prev_valid = gnt_valid;
      prev_id    = gnt_id;
      req = req | (8'($urandom) & 8'($urandom) & 8'($urandom));
      if (gnt_valid && $urandom_range(0, 5) == 0) req[gnt_id] = 1'b0;
      done = ($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
